// File: rtl/upower_decode_execute.sv
// Single-cycle decode + execute slice: main control, ALU control, B-operand mux and ALU.
// The only state is a registered copy of the ALU flags.
module upower_decode_execute #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic [1:0]       alu_op_main,
    output logic [3:0]       alu_ctl,
    output logic [31:0]      immediate,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             slt,
    output logic             overflow,
    output logic [3:0]       flags_q
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    logic [5:0]       opcode;
    logic [3:0]       sel_lo;
    logic [WIDTH-1:0] imm_w;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             ovf_add;
    logic             ovf_sub;
    logic [3:0]       flags_d;

    assign opcode    = instruction[31:26];
    assign immediate = {{16{instruction[15]}}, instruction[15:0]};
    assign imm_w     = {{(WIDTH-16){instruction[15]}}, instruction[15:0]};

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = 7'b0;
        alu_op_main = 2'b00;
        unique case (opcode)
            OP_RTYPE: begin
                {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = 7'b1001000;
                alu_op_main = 2'b10;
            end
            OP_LW: begin
                {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = 7'b0111100;
            end
            OP_SW: begin
                {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = 7'b0100010;
            end
            OP_BEQ: begin
                {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = 7'b0000001;
                alu_op_main = 2'b01;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch} = 7'b0101000;
                alu_op_main = 2'b11;
            end
            default: ;
        endcase
    end

    // Immediate-format opcodes substitute their own operation for the funct field.
    always_comb begin
        case (opcode)
            OP_ADDI: sel_lo = 4'b0000;
            OP_ANDI: sel_lo = 4'b0100;
            OP_ORI:  sel_lo = 4'b0101;
            default: sel_lo = instruction[3:0];
        endcase
    end

    always_comb begin
        alu_ctl = ALU_BAD;
        case (alu_op_main)
            2'b00: alu_ctl = ALU_ADD;
            2'b01: alu_ctl = ALU_SUB;
            default: begin
                case (sel_lo)
                    4'b0000: alu_ctl = ALU_ADD;
                    4'b0010: alu_ctl = ALU_SUB;
                    4'b0100: alu_ctl = ALU_AND;
                    4'b0101: alu_ctl = ALU_OR;
                    4'b0111: alu_ctl = ALU_NOR;
                    4'b1010: alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_BAD;
                endcase
            end
        endcase
    end

    assign b_op     = alu_src ? imm_w : op_b;
    assign add_full = {1'b0, op_a} + {1'b0, b_op};
    assign sub_full = {1'b0, op_a} + {1'b0, ~b_op} + (WIDTH+1)'(1);
    assign ovf_add  = (op_a[WIDTH-1] == b_op[WIDTH-1]) && (add_full[WIDTH-1] != op_a[WIDTH-1]);
    assign ovf_sub  = (op_a[WIDTH-1] != b_op[WIDTH-1]) && (sub_full[WIDTH-1] != op_a[WIDTH-1]);
    // Less-than is derived from the subtraction regardless of the selected operation.
    assign slt      = sub_full[WIDTH-1] ^ ovf_sub;

    always_comb begin
        result   = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (alu_ctl)
            ALU_AND: result = op_a & b_op;
            ALU_OR:  result = op_a | b_op;
            ALU_NOR: result = ~(op_a | b_op);
            ALU_ADD: begin
                result   = add_full[WIDTH-1:0];
                cout     = add_full[WIDTH];
                overflow = ovf_add;
            end
            ALU_SUB: begin
                result   = sub_full[WIDTH-1:0];
                cout     = sub_full[WIDTH];
                overflow = ovf_sub;
            end
            ALU_SLT: begin
                result   = {{(WIDTH-1){1'b0}}, slt};
                cout     = sub_full[WIDTH];
                overflow = ovf_sub;
            end
            default: result = '0;
        endcase
    end

    assign zero    = (result == '0);
    assign flags_d = {overflow, slt, cout, zero};

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) flags_q <= 4'b0000;
        else     flags_q <= flags_d;
    end

endmodule

// File: tb/tb_upower_decode_execute.sv
// Directed-vector bench for upower_decode_execute: the driver queues hand-computed
// expectations, a monitor compares them one clock later, including the registered flags.
module tb_upower_decode_execute;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic        rst;
        logic [6:0]  ctrl;   // {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch}
        logic [1:0]  aluop;
        logic [3:0]  ctl;
        logic [31:0] imm;
        logic [31:0] res;
        logic [3:0]  fl;     // {overflow,slt,cout,zero}
        logic [3:0]  flq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, op_a, op_b;
    logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
    logic [1:0]  alu_op_main;
    logic [3:0]  alu_ctl;
    logic [31:0] immediate, result;
    logic        zero, cout, slt, overflow;
    logic [3:0]  flags_q;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t exp_q[$];

    upower_decode_execute #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .op_a(op_a), .op_b(op_b),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .alu_op_main(alu_op_main), .alu_ctl(alu_ctl), .immediate(immediate), .result(result),
        .zero(zero), .cout(cout), .slt(slt), .overflow(overflow), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                                input logic r, input logic [6:0] ctrl, input logic [1:0] aluop,
                                input logic [3:0] ctl, input logic [31:0] imm, input logic [31:0] res,
                                input logic [3:0] fl, input logic [3:0] flq);
        vec_t v;
        v.instr = instr; v.a = a; v.b = b; v.rst = r; v.ctrl = ctrl; v.aluop = aluop;
        v.ctl = ctl; v.imm = imm; v.res = res; v.fl = fl; v.flq = flq;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        instruction = v.instr;
        op_a        = v.a;
        op_b        = v.b;
        rst         = v.rst;
        exp_q.push_back(v);
    endtask

    // Monitor: each posedge after a vector was applied, compare settled outputs and the new flags_q.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("ctrl[%08h]", e.instr),
                      {25'b0, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch},
                      {25'b0, e.ctrl});
                check($sformatf("aluop[%08h]", e.instr), {30'b0, alu_op_main}, {30'b0, e.aluop});
                check($sformatf("alu_ctl[%08h]", e.instr), {28'b0, alu_ctl}, {28'b0, e.ctl});
                check($sformatf("imm[%08h]", e.instr), immediate, e.imm);
                check($sformatf("result[%08h]", e.instr), result, e.res);
                check($sformatf("flags[%08h]", e.instr), {28'b0, overflow, slt, cout, zero}, {28'b0, e.fl});
                check($sformatf("flags_q[%08h]", e.instr), {28'b0, flags_q}, {28'b0, e.flq});
            end
        end
    end

    initial begin
        rst = 1'b1; instruction = '0; op_a = '0; op_b = '0;
        //          instr         A             B             rst ctrl        op     ctl      imm           result        flags    flags_q
        drive(mk(32'h0000_0000, 32'h0,        32'h0,        1, 7'b1001000, 2'b10, 4'b0010, 32'h0000_0000, 32'h0,         4'b0001, 4'b0000)); // reset
        drive(mk(32'h0000_0020, 32'h5,        32'h7,        0, 7'b1001000, 2'b10, 4'b0010, 32'h0000_0020, 32'd12,        4'b0100, 4'b0100)); // add
        drive(mk(32'h1000_0003, 32'h1234,     32'h1234,     0, 7'b0000001, 2'b01, 4'b0110, 32'h0000_0003, 32'h0,         4'b0011, 4'b0011)); // beq
        drive(mk(32'h0000_002A, 32'hFFFF_FFFF,32'h1,        0, 7'b1001000, 2'b10, 4'b0111, 32'h0000_002A, 32'h1,         4'b0110, 4'b0110)); // slt -1<1
        drive(mk(32'h0000_002A, 32'h1,        32'hFFFF_FFFF,0, 7'b1001000, 2'b10, 4'b0111, 32'h0000_002A, 32'h0,         4'b0001, 4'b0001)); // slt 1<-1
        drive(mk(32'h0000_0020, 32'h7FFF_FFFF,32'h1,        0, 7'b1001000, 2'b10, 4'b0010, 32'h0000_0020, 32'h8000_0000, 4'b1000, 4'b1000)); // add ovf
        drive(mk(32'h3000_8001, 32'hFFFF_0003,32'h0,        0, 7'b0101000, 2'b11, 4'b0000, 32'hFFFF_8001, 32'hFFFF_0001, 4'b0100, 4'b0100)); // andi
        drive(mk(32'h3400_00F0, 32'h0F,       32'h0,        0, 7'b0101000, 2'b11, 4'b0001, 32'h0000_00F0, 32'hFF,        4'b0100, 4'b0100)); // ori
        drive(mk(32'h8C00_0010, 32'h100,      32'h0,        0, 7'b0111100, 2'b00, 4'b0010, 32'h0000_0010, 32'h110,       4'b0000, 4'b0000)); // lw
        drive(mk(32'hAC00_FFFC, 32'h100,      32'h0,        0, 7'b0100010, 2'b00, 4'b0010, 32'hFFFF_FFFC, 32'hFC,        4'b0010, 4'b0010)); // sw
        drive(mk(32'hFFFF_FFFF, 32'h5,        32'h3,        0, 7'b0000000, 2'b00, 4'b0010, 32'hFFFF_FFFF, 32'h8,         4'b0000, 4'b0000)); // halt word
        drive(mk(32'h2000_FFFF, 32'h1,        32'h0,        0, 7'b0101000, 2'b11, 4'b0010, 32'hFFFF_FFFF, 32'h0,         4'b0011, 4'b0011)); // addi wrap
        drive(mk(32'h0000_0020, 32'h5,        32'h7,        1, 7'b1001000, 2'b10, 4'b0010, 32'h0000_0020, 32'd12,        4'b0100, 4'b0000)); // mid-run rst
        drive(mk(32'h0000_0027, 32'hF0F0_F0F0,32'h0F0F_0F00,0, 7'b1001000, 2'b10, 4'b1100, 32'h0000_0027, 32'h0000_000F, 4'b0100, 4'b0100)); // nor
        drive(mk(32'h0000_0001, 32'h5,        32'h3,        0, 7'b1001000, 2'b10, 4'b1111, 32'h0000_0001, 32'h0,         4'b0001, 4'b0001)); // bad funct
        drive(mk(32'h0000_0022, 32'h3,        32'h5,        0, 7'b1001000, 2'b10, 4'b0110, 32'h0000_0022, 32'hFFFF_FFFE, 4'b0100, 4'b0100)); // sub
        drive(mk(32'h0000_0024, 32'hC,        32'hA,        0, 7'b1001000, 2'b10, 4'b0000, 32'h0000_0024, 32'h8,         4'b0000, 4'b0000)); // and
        drive(mk(32'h0000_0025, 32'hC,        32'hA,        0, 7'b1001000, 2'b10, 4'b0001, 32'h0000_0025, 32'hE,         4'b0000, 4'b0000)); // or

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
